// File: rtl/sirv_mrom_icb_ctrl.sv
// ICB slave for the mask ROM: one synchronous ROM read per accepted command,
// in-order responses buffered in a small FIFO so reads can stream every cycle.
module sirv_mrom_icb_ctrl #(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int DP          = 1024,
  parameter int RSP_FIFO_DP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_icb_cmd_valid,
  output logic          rom_icb_cmd_ready,
  input  logic [AW-1:0] rom_icb_cmd_addr,
  input  logic          rom_icb_cmd_read,
  output logic          rom_icb_rsp_valid,
  input  logic          rom_icb_rsp_ready,
  output logic          rom_icb_rsp_err,
  output logic [DW-1:0] rom_icb_rsp_rdata,
  output logic          rom_cs,
  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  localparam int CW = $clog2(RSP_FIFO_DP + 1);
  localparam int PW = (RSP_FIFO_DP > 1) ? $clog2(RSP_FIFO_DP) : 1;

  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_fifo_cnt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_fifo_err  [RSP_FIFO_DP];
  logic [DW-1:0] r_fifo_data [RSP_FIFO_DP];
  logic          r_s1_valid;
  logic          r_s1_err;

  logic          w_accept;
  logic          w_err;
  logic          w_consume;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_s1_data;

  assign w_err = ~rom_icb_cmd_read
               | (rom_icb_cmd_addr[1:0] != 2'b00)
               | (32'(rom_icb_cmd_addr[AW-1:2]) >= 32'(DP));

  assign w_accept     = rom_icb_cmd_valid & rom_icb_cmd_ready;
  assign w_consume    = rom_icb_rsp_valid & rom_icb_rsp_ready;
  assign w_fifo_empty = (r_fifo_cnt == '0);

  // Ready may depend on rsp_ready: a same-cycle consume frees a slot.
  assign rom_icb_cmd_ready = (r_out_cnt < CW'(RSP_FIFO_DP)) | w_consume;

  assign rom_cs   = w_accept & ~w_err;
  assign rom_addr = rom_icb_cmd_addr[AW-1:2];

  assign w_s1_data = r_s1_err ? '0 : rom_dout;

  // s1 bypasses straight to the bus only when nothing older is queued.
  assign w_push = r_s1_valid & (~w_fifo_empty | ~rom_icb_rsp_ready);
  assign w_pop  = w_consume & ~w_fifo_empty;

  always_comb begin
    rom_icb_rsp_valid = r_s1_valid;
    rom_icb_rsp_err   = r_s1_err;
    rom_icb_rsp_rdata = w_s1_data;
    if (!w_fifo_empty) begin
      rom_icb_rsp_valid = 1'b1;
      rom_icb_rsp_err   = r_fifo_err[r_rptr];
      rom_icb_rsp_rdata = r_fifo_data[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_err <= w_err;
      if (w_accept && !w_consume)      r_out_cnt <= r_out_cnt + 1'b1;
      else if (!w_accept && w_consume) r_out_cnt <= r_out_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_cnt <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(RSP_FIFO_DP - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(RSP_FIFO_DP - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_err[r_wptr]  <= r_s1_err;
      r_fifo_data[r_wptr] <= w_s1_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_fifo_cnt == CW'(RSP_FIFO_DP))));

endmodule

// File: tb/tb_sirv_mrom_icb_ctrl.sv
// Bench for sirv_mrom_icb_ctrl: directed scenarios plus a randomized run
// checked against a transaction-queue model of the ICB slave.
module tb_sirv_mrom_icb_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // u0: DP=512, 2 outstanding; u1: DP=1024, 1 outstanding.
  logic        v0, rd0, rr0, ready0, rv0, rerr0, cs0;
  logic [11:0] a0;
  logic [31:0] rdata0, dout0;
  logic [9:0]  raddr0;
  logic        v1, rd1, rr1, ready1, rv1, rerr1, cs1;
  logic [11:0] a1;
  logic [31:0] rdata1, dout1;
  logic [9:0]  raddr1;

  sirv_mrom_icb_ctrl #(.AW(12), .DW(32), .DP(512), .RSP_FIFO_DP(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rom_icb_cmd_valid(v0), .rom_icb_cmd_ready(ready0), .rom_icb_cmd_addr(a0),
    .rom_icb_cmd_read(rd0), .rom_icb_rsp_valid(rv0), .rom_icb_rsp_ready(rr0),
    .rom_icb_rsp_err(rerr0), .rom_icb_rsp_rdata(rdata0),
    .rom_cs(cs0), .rom_addr(raddr0), .rom_dout(dout0));

  sirv_mrom_icb_ctrl #(.AW(12), .DW(32), .DP(1024), .RSP_FIFO_DP(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rom_icb_cmd_valid(v1), .rom_icb_cmd_ready(ready1), .rom_icb_cmd_addr(a1),
    .rom_icb_cmd_read(rd1), .rom_icb_rsp_valid(rv1), .rom_icb_rsp_ready(rr1),
    .rom_icb_rsp_err(rerr1), .rom_icb_rsp_rdata(rdata1),
    .rom_cs(cs1), .rom_addr(raddr1), .rom_dout(dout1));

  function automatic logic [31:0] romf(input logic [9:0] idx);
    return {22'd0, idx} * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Synchronous ROM; data is garbage unless the previous cycle strobed.
  always @(posedge clk) begin
    dout0 <= cs0 ? romf(raddr0) : $urandom;
    dout1 <= cs1 ? romf(raddr1) : $urandom;
  end

  task automatic drv0(input logic v, input logic [11:0] a, input logic r, input logic rr);
    @(negedge clk);
    v0 = v; a0 = a; rd0 = r; rr0 = rr;
    #4;
  endtask

  task automatic drv1(input logic v, input logic [11:0] a, input logic r, input logic rr);
    @(negedge clk);
    v1 = v; a1 = a; rd1 = r; rr1 = rr;
    #4;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL reset_rv0 got=%0h exp=0", rv0); end
    checks++; if (cs0 !== 1'b0) begin failures++; $display("FAIL reset_cs0 got=%0h exp=0", cs0); end
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL reset_rv1 got=%0h exp=0", rv1); end
    @(negedge clk); rst_n = 1'b1;
    drv0(0, 0, 1, 1);
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%0h exp=1", ready0); end
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL reset_rv0_post got=%0h exp=0", rv0); end
  endtask

  task automatic test_stream;
    drv0(1, 12'h000, 1, 1);
    checks++; if ({ready0, cs0, rv0} !== 3'b110) begin failures++; $display("FAIL stream_first got=%0b exp=110", {ready0, cs0, rv0}); end
    for (int unsigned k = 1; k <= 3; k++) begin
      drv0(k < 3, 12'(4 * k), 1, 1);
      checks++;
      if ({rv0, rerr0, rdata0, ready0} !== {2'b10, romf(10'(k - 1)), 1'b1}) begin
        failures++;
        $display("FAIL stream_rsp%0d got=%0h exp=%0h", k, {rv0, rerr0, rdata0, ready0}, {2'b10, romf(10'(k - 1)), 1'b1});
      end
    end
    drv0(0, 0, 1, 1);
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL stream_idle got=%0h exp=0", rv0); end
  endtask

  task automatic test_back_pressure;
    drv0(1, 12'h000, 1, 0);
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL bp_rdy1 got=%0h exp=1", ready0); end
    drv0(1, 12'h004, 1, 0);
    checks++; if ({ready0, rv0, rdata0} !== {2'b11, romf(0)}) begin failures++; $display("FAIL bp_c2 got=%0h exp=%0h", {ready0, rv0, rdata0}, {2'b11, romf(0)}); end
    drv0(1, 12'h008, 1, 0);
    checks++; if ({ready0, rv0, rdata0} !== {2'b01, romf(0)}) begin failures++; $display("FAIL bp_full got=%0h exp=%0h", {ready0, rv0, rdata0}, {2'b01, romf(0)}); end
    drv0(1, 12'h008, 1, 1);
    checks++; if ({ready0, rv0, rdata0} !== {2'b11, romf(0)}) begin failures++; $display("FAIL bp_release got=%0h exp=%0h", {ready0, rv0, rdata0}, {2'b11, romf(0)}); end
    for (int unsigned k = 1; k <= 2; k++) begin
      drv0(0, 0, 1, 1);
      checks++; if ({rv0, rerr0, rdata0} !== {2'b10, romf(10'(k))}) begin failures++; $display("FAIL bp_drain%0d got=%0h exp=%0h", k, {rv0, rerr0, rdata0}, {2'b10, romf(10'(k))}); end
    end
    drv0(0, 0, 1, 1);
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0h exp=0", rv0); end
  endtask

  task automatic test_errors;
    logic [11:0] ea [4] = '{12'h010, 12'h002, 12'h800, 12'h7FC};
    logic        er [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int unsigned k = 0; k <= 4; k++) begin
      drv0(k < 4, (k < 4) ? ea[k] : 12'h0, (k < 4) ? er[k] : 1'b1, 1);
      if (k < 4) begin
        checks++; if (cs0 !== !ee[k]) begin failures++; $display("FAIL err_cs%0d got=%0h exp=%0h", k, cs0, !ee[k]); end
      end
      if (k > 0) begin
        checks++;
        if ({rv0, rerr0, rdata0} !== {1'b1, ee[k-1], ee[k-1] ? 32'h0 : romf(10'h1FF)}) begin
          failures++;
          $display("FAIL err_rsp%0d got=%0h exp=%0h", k - 1, {rv0, rerr0, rdata0}, {1'b1, ee[k-1], ee[k-1] ? 32'h0 : romf(10'h1FF)});
        end
      end
    end
  endtask

  task automatic test_mixed_order;
    logic [11:0] ma [3] = '{12'h000, 12'h004, 12'h008};
    logic        mr [3] = '{1'b1, 1'b0, 1'b1};
    logic [32:0] me [3];
    int unsigned iss = 0, got = 0;
    me[0] = {1'b0, romf(0)}; me[1] = 33'h1_0000_0000; me[2] = {1'b0, romf(2)};
    for (int unsigned c = 0; c < 20 && got < 3; c++) begin
      drv0(iss < 3, (iss < 3) ? ma[iss] : 12'h0, (iss < 3) ? mr[iss] : 1'b1, c[0] == 1'b0);
      if (rv0 && rr0) begin
        checks++; if ({rerr0, rdata0} !== me[got]) begin failures++; $display("FAIL mixed_rsp%0d got=%0h exp=%0h", got, {rerr0, rdata0}, me[got]); end
        got++;
      end
      if (v0 && ready0) iss++;
    end
    checks++; if (got != 3) begin failures++; $display("FAIL mixed_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_reset_mid;
    drv0(1, 12'h000, 1, 0);
    drv0(1, 12'h004, 1, 0);
    drv0(0, 12'h000, 1, 0);
    checks++; if ({rv0, ready0} !== 2'b10) begin failures++; $display("FAIL rmid_pre got=%0b exp=10", {rv0, ready0}); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    checks++; if ({rv0, ready0} !== 2'b01) begin failures++; $display("FAIL rmid_async got=%0b exp=01", {rv0, ready0}); end
    @(negedge clk); rst_n = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      drv0(0, 12'h000, 1, 1);
      checks++; if ({rv0, ready0} !== 2'b01) begin failures++; $display("FAIL rmid_post%0d got=%0b exp=01", k, {rv0, ready0}); end
    end
    drv0(1, 12'h008, 1, 1);
    drv0(0, 12'h000, 1, 1);
    checks++; if ({rv0, rerr0, rdata0} !== {2'b10, romf(2)}) begin failures++; $display("FAIL rmid_fresh got=%0h exp=%0h", {rv0, rerr0, rdata0}, {2'b10, romf(2)}); end
    drv0(0, 12'h000, 1, 1);
  endtask

  task automatic test_fifo_dp1;
    for (int unsigned k = 0; k <= 8; k++) begin
      drv1(k < 8, 12'(4 * k), 1, 1);
      checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL dp1_rdy%0d got=%0h exp=1", k, ready1); end
      if (k > 0) begin
        checks++; if ({rv1, rerr1, rdata1} !== {2'b10, romf(10'(k - 1))}) begin failures++; $display("FAIL dp1_rsp%0d got=%0h exp=%0h", k, {rv1, rerr1, rdata1}, {2'b10, romf(10'(k - 1))}); end
      end
    end
    drv1(1, 12'h000, 1, 0);
    drv1(1, 12'h004, 1, 0);
    checks++; if ({ready1, rv1, rdata1} !== {2'b01, romf(0)}) begin failures++; $display("FAIL dp1_stall got=%0h exp=%0h", {ready1, rv1, rdata1}, {2'b01, romf(0)}); end
    drv1(1, 12'h004, 1, 1);
    checks++; if ({ready1, rv1, rdata1} !== {2'b11, romf(0)}) begin failures++; $display("FAIL dp1_resume got=%0h exp=%0h", {ready1, rv1, rdata1}, {2'b11, romf(0)}); end
    drv1(0, 12'h000, 1, 1);
    checks++; if ({rv1, rdata1} !== {1'b1, romf(1)}) begin failures++; $display("FAIL dp1_last got=%0h exp=%0h", {rv1, rdata1}, {1'b1, romf(1)}); end
    drv1(0, 12'h000, 1, 1);
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL dp1_idle got=%0h exp=0", rv1); end
  endtask

  // Model: every response for a command accepted in an earlier cycle is
  // available now, so rsp_valid == queue non-empty and occupancy == queue size.
  task automatic test_random;
    logic [32:0] q[$];
    logic [32:0] h;
    logic        v, r, rr, e, exp_rv, exp_rdy;
    logic [11:0] a;
    for (int unsigned c = 0; c < 410; c++) begin
      v  = (c < 400) && ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 7) != 0);
      a  = ($urandom_range(0, 9) < 7) ? {1'b0, 9'($urandom_range(0, 511)), 2'b00} : 12'($urandom);
      rr = (c >= 400) || ($urandom_range(0, 2) != 0);
      drv0(v, a, r, rr);
      e       = !r || (a[1:0] != 2'b00) || (a[11:2] >= 10'd512);
      exp_rv  = (q.size() != 0);
      exp_rdy = (q.size() < 2) || (exp_rv && rr);
      checks++; if (rv0 !== exp_rv) begin failures++; $display("FAIL rnd_rv c=%0d got=%0h exp=%0h", c, rv0, exp_rv); end
      checks++; if (ready0 !== exp_rdy) begin failures++; $display("FAIL rnd_rdy c=%0d got=%0h exp=%0h", c, ready0, exp_rdy); end
      checks++; if (cs0 !== (v && exp_rdy && !e)) begin failures++; $display("FAIL rnd_cs c=%0d got=%0h exp=%0h", c, cs0, v && exp_rdy && !e); end
      if (exp_rv && rr) begin
        h = q.pop_front();
        checks++; if ({rerr0, rdata0} !== h) begin failures++; $display("FAIL rnd_rsp c=%0d got=%0h exp=%0h", c, {rerr0, rdata0}, h); end
      end
      if (v && exp_rdy) q.push_back({e, e ? 32'h0 : romf(a[11:2])});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; a0 = '0; rd0 = 1; rr0 = 1;
    v1 = 0; a1 = '0; rd1 = 1; rr1 = 1;
    repeat (3) @(negedge clk);
    test_reset();
    test_stream();
    test_back_pressure();
    test_errors();
    test_mixed_order();
    test_reset_mid();
    test_fifo_dp1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
